// File: rtl/neuron_mac_writer.sv
// Accumulates N_INPUTS signed fixed-point products, then writes one saturated 8-bit result to neuron memory.
// Optional build macro NEURON_MAC_RELU_EN clamps negative results to zero before the write.
module neuron_mac_writer #(
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] neuro_write_addr,
  input  logic       in_valid,
  input  logic [7:0] weight_data,
  input  logic [7:0] neuro_data,
  output logic       busy,
  output logic       write_en,
  output logic [7:0] write_addr,
  output logic [7:0] write_data,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(N_INPUTS);

  state_t             state, state_nxt;
  logic signed [23:0] acc;
  logic [7:0]         count;
  logic [7:0]         addr_q;

  logic               all_in;
  logic               take;
  logic signed [15:0] w_ext, n_ext, product;
  logic signed [23:0] shifted;
  logic [7:0]         sat;
  logic [7:0]         result;

  // The FSM stays in ACCUM for one cycle after the final pair lands, so the
  // saturation logic sees a registered accumulator.
  assign all_in  = (count == LAST_COUNT);
  assign take    = (state == ACCUM) && in_valid && !all_in;
  assign w_ext   = $signed({{8{weight_data[7]}}, weight_data});
  assign n_ext   = $signed({{8{neuro_data[7]}}, neuro_data});
  assign product = w_ext * n_ext;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (all_in) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      count  <= '0;
      addr_q <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      count  <= '0;
      addr_q <= neuro_write_addr;
    end else if (take) begin
      acc   <= acc + {{8{product[15]}}, product};
      count <= count + 8'd1;
    end
  end

  // Arithmetic shift drops the fraction bits, then clamp to the signed 8-bit range.
  always_comb begin
    shifted = acc >>> FRAC_BITS;
    if (shifted > 24'sd127)       sat = 8'h7F;
    else if (shifted < -24'sd128) sat = 8'h80;
    else                          sat = shifted[7:0];
  end

`ifdef NEURON_MAC_RELU_EN
  assign result = sat[7] ? 8'h00 : sat;
`else
  assign result = sat;
`endif

  assign busy       = (state == ACCUM) || (state == WRITE);
  assign write_en   = (state == WRITE);
  assign done       = write_en;
  assign write_addr = write_en ? addr_q : 8'h00;
  assign write_data = write_en ? result : 8'h00;

endmodule

// File: doc/neuron_mac_writer.md
NEURON_MAC_WRITER -- requirements
Module: neuron_mac_writer

Interface
REQ-001 Parameter N_INPUTS, default 4, meaning: products accumulated per neuron (1..255).
REQ-002 Parameter FRAC_BITS, default 4, meaning: fixed-point fraction bits of both operands and of the result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin one neuron computation; sampled only in IDLE.
REQ-006 neuro_write_addr  input  8  destination address; captured on accepted start.
REQ-007 in_valid  input  1  weight_data/neuro_data pair valid this cycle.
REQ-008 weight_data  input  8  signed weight operand.
REQ-009 neuro_data  input  8  signed neuron operand.
REQ-010 busy  output  1  high in ACCUM and WRITE.
REQ-011 write_en  output  1  one-cycle write strobe to neuron memory.
REQ-012 write_addr  output  8  address qualified by write_en.
REQ-013 write_data  output  8  signed result qualified by write_en.
REQ-014 done  output  1  one-cycle pulse, coincident with write_en.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, WRITE; any other encoding SHALL return to IDLE next cycle.
REQ-016 IDLE: start=1 -> ACCUM next cycle; accumulator cleared, count cleared, neuro_write_addr captured.
REQ-017 ACCUM: each cycle with in_valid=1 -> accumulator += sign-extended 16-bit product weight_data*neuro_data, count += 1.
REQ-018 ACCUM: in_valid=0 -> accumulator and count hold; no timeout.
REQ-019 When the N_INPUTS-th pair is accepted, FSM SHALL move to WRITE on the next edge.
REQ-020 Accumulator SHALL be 24-bit signed; no wrap for N_INPUTS<=255 at full-scale operands.
REQ-021 Result = accumulator arithmetically shifted right by FRAC_BITS, saturated to [-128, 127].
REQ-022 WRITE: write_en=1, done=1, write_addr=captured address, write_data=result for exactly one cycle; next state IDLE.
REQ-023 Latency: write_en asserts exactly 1 cycle after the edge accepting the last pair (N_INPUTS+2 cycles start-to-write with continuous in_valid).
REQ-024 start while busy SHALL be ignored; captured address SHALL not change.
REQ-025 in_valid in IDLE or WRITE SHALL be ignored.
REQ-026 start in the cycle after WRITE (IDLE) SHALL be accepted; back-to-back neurons allowed with one idle cycle.
REQ-027 write_data and write_addr SHALL be 0 whenever write_en=0.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, accumulator=0, count=0, captured address=0.
REQ-029 Reset values: busy=0, write_en=0, done=0, write_addr=0, write_data=0.
REQ-030 Reset mid-ACCUM or in WRITE SHALL abort with no write strobe; partial sum discarded.
REQ-031 After deassertion, first start accepted on the first rising edge with reset=0.

Configuration
REQ-032 Macro NEURON_MAC_RELU_EN: when defined, negative saturated results SHALL be written as 0 (ReLU applied after saturation).
REQ-033 Without NEURON_MAC_RELU_EN the saturated signed result SHALL be written unchanged.

Verification
REQ-034 N_INPUTS=4, FRAC_BITS=4, addr=8'h10, pairs (16,16)x4 continuous -> write_en at cycle 6 after start, write_data=8'd64, write_addr=8'h10, done=1 one cycle.
REQ-035 Pairs (127,127)x4 -> write_data=8'd127 (saturated); pairs (-128,127)x4 -> 8'h80 without macro, 8'h00 with NEURON_MAC_RELU_EN.
REQ-036 Pairs (16,-16)x4 with in_valid gapped (1,0,0,1,1,0,1) -> write_data=8'hC0 without macro, 8'h00 with macro; write_en only after 4th valid.
REQ-037 Assert reset after 2 pairs accepted -> busy=0 same cycle, no write_en ever; subsequent start with addr 8'h22 and (16,16)x4 -> 8'd64 at 8'h22.
REQ-038 start re-asserted with addr 8'h33 during ACCUM -> ignored, write_addr=original 8'h10; start on cycle after done -> accepted.
